// File: rtl/clock_period_meter_pkg.sv
// Shared definitions for the clock period meter: FSM state encoding and default counter width.
package clock_period_meter_pkg;

    localparam int DEFAULT_CNT_W = 28;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_RISE = 2'd1,
        MEAS_HIGH = 2'd2,
        MEAS_LOW  = 2'd3
    } meas_state_t;

endpackage

// File: rtl/clock_period_meter_sync_edge_detect.sv
// Two-flop synchronizer followed by a history flop, giving a clean level plus
// single-cycle rise/fall strobes for slow or asynchronous inputs.
module sync_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta;
    logic sync;
    logic prev;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta <= 1'b0;
            sync <= 1'b0;
            prev <= 1'b0;
        end else begin
            meta <= d;
            sync <= meta;
            prev <= sync;
        end
    end

    assign level = sync;
    assign rise  = sync & ~prev;
    assign fall  = ~sync & prev;

endmodule

// File: rtl/clock_period_meter.sv
// Single-shot measurement of the period and high time of a slow input, in clk cycles,
// with a start-to-done timeout guarding against a stuck input.
module clock_period_meter
    import clock_period_meter_pkg::*;
#(
    parameter int CNT_W   = DEFAULT_CNT_W,
    parameter int TIMEOUT = 200000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sig_in,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] period_cnt,
    output logic [CNT_W-1:0] high_cnt
);

    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT);

    meas_state_t      state;
    logic [CNT_W-1:0] timer;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] high_capture;
    logic             rise_det;
    logic             fall_det;

    sync_edge_detect u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (sig_in),
        .level (),
        .rise  (rise_det),
        .fall  (fall_det)
    );

    // The high time is held privately until the closing rise so published results
    // only ever change together with done.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            timeout      <= 1'b0;
            period_cnt   <= '0;
            high_cnt     <= '0;
            timer        <= '0;
            cnt          <= '0;
            high_capture <= '0;
        end else begin
            done <= 1'b0;
            if (state != IDLE && timer == TIMEOUT_VAL) begin
                state      <= IDLE;
                done       <= 1'b1;
                timeout    <= 1'b1;
                busy       <= 1'b0;
                period_cnt <= '0;
                high_cnt   <= '0;
            end else begin
                if (busy) begin
                    timer <= timer + 1'b1;
                end
                case (state)
                    IDLE: begin
                        if (start) begin
                            state <= WAIT_RISE;
                            busy  <= 1'b1;
                            timer <= {{(CNT_W-1){1'b0}}, 1'b1};
                        end
                    end
                    WAIT_RISE: begin
                        if (rise_det) begin
                            cnt   <= {{(CNT_W-1){1'b0}}, 1'b1};
                            state <= MEAS_HIGH;
                        end
                    end
                    MEAS_HIGH: begin
                        cnt <= cnt + 1'b1;
                        if (fall_det) begin
                            high_capture <= cnt;
                            state        <= MEAS_LOW;
                        end
                    end
                    MEAS_LOW: begin
                        cnt <= cnt + 1'b1;
                        if (rise_det) begin
                            period_cnt <= cnt;
                            high_cnt   <= high_capture;
                            done       <= 1'b1;
                            timeout    <= 1'b0;
                            busy       <= 1'b0;
                            state      <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/clock_period_meter.md
Name: clock_period_meter

Overview:
- Consumes a slow, divided clock or pulse train such as the clock divider's output, from an asynchronous or same-domain source.
- Measures that signal against the fast system clock and reports its period and high time in clk cycles.
- Acts as the receiving-end check for the divider: a bench or top-level can recover DIVISOR and duty cycle from it.
- Single-shot: one measurement per start request, with timeout protection against a stuck input.

Parameters:
- CNT_W, 28, width of all cycle counters and result outputs. Matches the divider's counter width.
- TIMEOUT, 200000000, maximum clk cycles from start acceptance to completion. Must be < 2**CNT_W.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- sig_in  input  1  signal under measurement; may be asynchronous to clk.
- start  input  1  request one measurement; sampled only in IDLE.
- busy  output  1  high from start acceptance until the cycle done is asserted.
- done  output  1  one-cycle pulse when results are valid.
- timeout  output  1  valid with done; 1 = measurement aborted.
- period_cnt  output  CNT_W  clk cycles between two successive sig_in rising edges.
- high_cnt  output  CNT_W  clk cycles between a rising edge and the following falling edge.

Behaviour:
- Reset (reset==0, async) forces the following; released synchronously on the next clk edge after reset goes 1:
  - state=IDLE; busy=0, done=0, timeout=0, period_cnt=0, high_cnt=0.
  - Synchronizer and edge flops cleared to 0.
- Input path:
  - 2-flop synchronizer, then a third flop holding the previous level.
  - rise_det = sync & ~prev; fall_det = ~sync & prev.
  - Detection occurs 3 clk cycles after an sig_in transition. The latency is identical for both edges, so differences are exact.
- States IDLE, WAIT_RISE, MEAS_HIGH, MEAS_LOW.
  - IDLE: start==1 -> WAIT_RISE; busy<=1; timer<=1; done<=0. start in any other state is ignored.
  - WAIT_RISE: on rise_det -> MEAS_HIGH; period counter<=1.
  - MEAS_HIGH: period counter increments each cycle. On fall_det -> high_cnt<=counter value, go to MEAS_LOW.
  - MEAS_LOW: period counter increments. On rise_det -> period_cnt<=counter value; done<=1, timeout<=0, busy<=0; go to IDLE.
- Counting rule: the rise_det cycle counts as 1. Result = number of clk cycles from one detection to the next. An ideal divider with DIVISOR D (even) yields period_cnt=D, high_cnt=D/2.
- An edge that is already in progress at start is not measured; measurement begins at the first rise_det seen in WAIT_RISE.
- Timeout:
  - The timer increments every cycle while busy.
  - If the timer reaches TIMEOUT in any non-IDLE state: done<=1, timeout<=1, busy<=0, period_cnt<=0, high_cnt<=0; go to IDLE.
  - Timeout takes priority over a completing rise_det in the same cycle.
- Saturation: counters never wrap, because TIMEOUT < 2**CNT_W bounds them.
- Results hold their values until the next done. done is high for exactly one cycle.
- Glitches shorter than one clk cycle may be missed; no filtering beyond the synchronizer.
- Async reset mid-measurement aborts immediately: no done pulse, outputs cleared.

Decomposition:
- Shared package holds:
  - state encoding constants: IDLE=2'd0, WAIT_RISE=2'd1, MEAS_HIGH=2'd2, MEAS_LOW=2'd3;
  - the default CNT_W.
- One natural sub-module: sync_edge_detect (2-flop synchronizer plus prev flop). It has ports clk, reset, d, level, rise, fall, and is reusable by other blocks sampling slow signals.

Test Plan:
- sig_in from the divider with DIVISOR=10 on the same clk, then start pulse -> done within 30 cycles; period_cnt=10, high_cnt=5, timeout=0.
- Asymmetric input, 3 cycles high / 7 low, repeating -> period_cnt=10, high_cnt=3.
- sig_in stuck at 0 with TIMEOUT=50, then start -> done exactly 50 cycles after start acceptance; timeout=1, both counts 0.
- sig_in rises, then stays high (TIMEOUT=50) -> timeout=1, high_cnt=0, no spurious completion.
- start re-pulsed during MEAS_LOW -> ignored; single done with correct counts; busy stays high throughout.
- reset driven low mid-MEAS_HIGH -> all outputs 0 immediately, with no clk edge needed. After release, a fresh start gives correct results.
